// File: rtl/test_arbiter.sv
// test_arbiter: round-robin arbiter feeding a fixed-latency datapath, routing results back by tag.
module test_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dp_in_valid,
  output logic [DATA_W-1:0]         dp_in,
  input  logic                      dp_out_valid,
  input  logic [DATA_W-1:0]         dp_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      idle,
  output logic                      err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] last_grant, gid, cand;
  logic [IW-1:0] tag_id [LATENCY];
  logic [LATENCY-1:0] tag_v;
  logic [CW-1:0] inflight, inflight_nxt, sup_cnt;
  logic xfer, rsp, err_q;
  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    xfer = 1'b0;
    gid = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand] && state == RUN && !reset) begin
        xfer = 1'b1;
        gid = cand;
      end
    end
  end
  assign req_ready   = xfer ? NUM_REQ'(1) << gid : '0;
  assign dp_in_valid = xfer;
  assign dp_in       = xfer ? req_data[gid*DATA_W +: DATA_W] : '0;
  assign rsp       = tag_v[LATENCY-1] && dp_out_valid && !reset;
  assign rsp_valid = rsp ? NUM_REQ'(1) << tag_id[LATENCY-1] : '0;
  assign rsp_data  = rsp ? dp_out : '0;
  assign idle      = reset || state == IDLE;
  assign err       = err_q && !reset;
  always_comb begin
    inflight_nxt = inflight;
    if (xfer && !rsp && inflight != CW'(LATENCY))
      inflight_nxt = inflight + 1'b1;
    else if (rsp && !xfer && inflight != '0)
      inflight_nxt = inflight - 1'b1;
  end
  // Exit decisions look at the post-cycle count so a grant coinciding with en falling still drains.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = en ? RUN : IDLE;
      RUN:     state_nxt = en ? RUN : (inflight_nxt == '0 ? IDLE : DRAIN);
      DRAIN:   state_nxt = en ? RUN : (inflight_nxt == '0 ? IDLE : DRAIN);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      tag_v      <= '0;
      inflight   <= '0;
      err_q      <= 1'b0;
      sup_cnt    <= CW'(LATENCY);
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (xfer)
        last_grant <= gid;
      for (int s = LATENCY - 1; s > 0; s--)
        tag_v[s] <= tag_v[s-1];
      tag_v[0] <= xfer;
      if (sup_cnt == '0 && tag_v[LATENCY-1] != dp_out_valid)
        err_q <= 1'b1;
      if (sup_cnt != '0)
        sup_cnt <= sup_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int s = LATENCY - 1; s > 0; s--)
      tag_id[s] <= tag_id[s-1];
    tag_id[0] <= gid;
  end
endmodule

// File: tb/tb_test_arbiter.sv
// tb_test_arbiter: directed vector table plus randomized run against a queue-based reference model.
module tb_test_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic reset, en, dp_in_valid, dp_out_valid, idle, err;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_data;
  logic [W-1:0] dp_in, dp_out, rsp_data;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  test_arbiter #(.NUM_REQ(N), .DATA_W(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_in_valid(dp_in_valid), .dp_in(dp_in),
    .dp_out_valid(dp_out_valid), .dp_out(dp_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .idle(idle), .err(err)
  );
  typedef struct {
    logic rst, en;
    logic [3:0] rv;
    logic [31:0] rd;
    logic dov;
    logic [7:0] dout;
    logic [3:0] ready;
    logic dpv;
    logic [7:0] dpin;
    logic [3:0] rsp;
    logic [7:0] rdata;
    logic idl, er;
  } vec_t;
  typedef struct {
    int id;
    logic [7:0] d;
    int due;
  } tag_t;
  vec_t vecs[25];
  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask
  task automatic check_all(input int cyc, input logic [3:0] rdy, input logic dpv, input logic [7:0] dpin,
                           input logic [3:0] rsp, input logic [7:0] rdata, input logic idl, input logic er);
    chk("req_ready", cyc, 32'(req_ready), 32'(rdy));
    chk("dp_in_valid", cyc, 32'(dp_in_valid), 32'(dpv));
    chk("dp_in", cyc, 32'(dp_in), 32'(dpin));
    chk("rsp_valid", cyc, 32'(rsp_valid), 32'(rsp));
    chk("rsp_data", cyc, 32'(rsp_data), 32'(rdata));
    chk("idle", cyc, 32'(idle), 32'(idl));
    chk("err", cyc, 32'(err), 32'(er));
  endtask
  initial begin
    tag_t q[$];
    int m_state, m_lg, m_sup, gid, now;
    logic m_err, gnt, tv;
    logic [3:0] e_rdy, e_rsp;
    logic [7:0] e_din, e_rdata;
    vecs = '{
      '{1'b1,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b1,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'h4,32'h00100000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'h4,32'h00100000,1'b0,8'h00, 4'h4,1'b1,8'h10,4'h0,8'h00,1'b0,1'b0},
      '{1'b0,1'b1,4'h0,32'h00000000,1'b1,8'h11, 4'h0,1'b0,8'h00,4'h4,8'h11,1'b0,1'b0},
      '{1'b1,1'b1,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'hF,32'h43424140,1'b0,8'h00, 4'h1,1'b1,8'h40,4'h0,8'h00,1'b0,1'b0},
      '{1'b0,1'b1,4'hF,32'h43424140,1'b1,8'h41, 4'h2,1'b1,8'h41,4'h1,8'h41,1'b0,1'b0},
      '{1'b0,1'b1,4'hF,32'h43424140,1'b1,8'h42, 4'h4,1'b1,8'h42,4'h2,8'h42,1'b0,1'b0},
      '{1'b0,1'b1,4'hF,32'h43424140,1'b1,8'h43, 4'h8,1'b1,8'h43,4'h4,8'h43,1'b0,1'b0},
      '{1'b0,1'b1,4'hF,32'h43424140,1'b1,8'h44, 4'h1,1'b1,8'h40,4'h8,8'h44,1'b0,1'b0},
      '{1'b0,1'b1,4'h0,32'h00000000,1'b1,8'h41, 4'h0,1'b0,8'h00,4'h1,8'h41,1'b0,1'b0},
      '{1'b0,1'b0,4'h2,32'h0000FF00,1'b0,8'h00, 4'h2,1'b1,8'hFF,4'h0,8'h00,1'b0,1'b0},
      '{1'b0,1'b0,4'h2,32'h0000FF00,1'b1,8'h00, 4'h0,1'b0,8'h00,4'h2,8'h00,1'b0,1'b0},
      '{1'b0,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b0,4'h0,32'h00000000,1'b1,8'h55, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b1},
      '{1'b0,1'b1,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b1},
      '{1'b1,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b1,4'h8,32'h77000000,1'b0,8'h00, 4'h8,1'b1,8'h77,4'h0,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,4'h0,32'h00000000,1'b1,8'h78, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b0,4'h0,32'h00000000,1'b1,8'h79, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0},
      '{1'b0,1'b0,4'h0,32'h00000000,1'b0,8'h00, 4'h0,1'b0,8'h00,4'h0,8'h00,1'b1,1'b0}
    };
    reset = 1'b1; en = 1'b0; req_valid = '0; req_data = '0; dp_out_valid = 1'b0; dp_out = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; en = vecs[i].en; req_valid = vecs[i].rv; req_data = vecs[i].rd;
      dp_out_valid = vecs[i].dov; dp_out = vecs[i].dout;
      #2;
      check_all(i, vecs[i].ready, vecs[i].dpv, vecs[i].dpin, vecs[i].rsp, vecs[i].rdata, vecs[i].idl, vecs[i].er);
    end
    m_state = 0; m_lg = N - 1; m_sup = LAT; m_err = 1'b0; now = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(99) == 0);
      en = $urandom_range(99) < 80;
      req_valid = N'($urandom);
      req_data = $urandom;
      tv = q.size() > 0 && q[0].due == now;
      dp_out_valid = tv || ($urandom_range(199) == 0);
      dp_out = tv ? q[0].d + 8'd1 : 8'($urandom);
      gnt = 1'b0; gid = 0;
      for (int k = 1; k <= N; k++)
        if (!gnt && m_state == 1 && req_valid[(m_lg + k) % N]) begin
          gnt = 1'b1;
          gid = (m_lg + k) % N;
        end
      if (reset) gnt = 1'b0;
      e_rdy = gnt ? 4'(1 << gid) : 4'h0;
      e_din = gnt ? req_data[gid*W +: W] : 8'h00;
      e_rsp = (!reset && tv && dp_out_valid) ? 4'(1 << q[0].id) : 4'h0;
      e_rdata = (!reset && tv && dp_out_valid) ? dp_out : 8'h00;
      #2;
      check_all(1000 + i, e_rdy, gnt, e_din, e_rsp, e_rdata, reset || m_state == 0, m_err && !reset);
      if (reset) begin
        m_state = 0; m_lg = N - 1; m_sup = LAT; m_err = 1'b0;
        q.delete();
      end else begin
        if (m_sup == 0 && tv != dp_out_valid) m_err = 1'b1;
        if (m_sup > 0) m_sup--;
        if (tv && dp_out_valid) void'(q.pop_front());
        if (gnt) begin
          q.push_back('{gid, req_data[gid*W +: W], now + LAT});
          m_lg = gid;
        end
        if (en) m_state = 1;
        else if (m_state != 0) m_state = q.size() == 0 ? 0 : 2;
      end
      now++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/test_arbiter.md
TEST_ARBITER -- requirements
Module: test_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the increment datapath (2..8).
REQ-002 Parameter DATA_W, default 8: data width of requests and responses.
REQ-003 Parameter LATENCY, default 1: fixed datapath latency in cycles, from dp_in_valid to dp_out_valid (1..4).
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port en  in  1: enable; grants are issued only while the FSM is in RUN.
REQ-007 Port req_valid  in  NUM_REQ: per-requester request valid.
REQ-008 Port req_data  in  NUM_REQ*DATA_W: per-requester operand; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port req_ready  out  NUM_REQ: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 Port dp_in_valid  out  1: valid to the datapath input.
REQ-011 Port dp_in  out  DATA_W: operand to the datapath input.
REQ-012 Port dp_out_valid  in  1: valid from the datapath output.
REQ-013 Port dp_out  in  DATA_W: result from the datapath output.
REQ-014 Port rsp_valid  out  NUM_REQ: one-hot response strobe, routed to the requester that issued the operand.
REQ-015 Port rsp_data  out  DATA_W: response data, equal to dp_out.
REQ-016 Port idle  out  1: high when the FSM is in IDLE.
REQ-017 Port err  out  1: sticky tag/valid mismatch flag.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN. Transitions: IDLE->RUN when en=1; RUN->IDLE when en=0 and inflight=0; RUN->DRAIN when en=0 and inflight>0; DRAIN->RUN when en=1; DRAIN->IDLE when en=0 and inflight=0.
REQ-019 Arbitration runs only in RUN. req_ready is combinational from req_valid. At most one bit of req_ready is high per cycle, and only for a requester with req_valid high. req_ready is all-zero in IDLE and DRAIN.
REQ-020 Arbitration is round-robin. The search starts at (last_grant+1) mod NUM_REQ. last_grant updates only on a transfer.
REQ-021 When a transfer occurs: dp_in_valid=1 and dp_in=the granted requester's req_data, in the same cycle. Otherwise dp_in_valid=0 and dp_in=0.
REQ-022 A tag pipeline of LATENCY stages, each {valid, id[clog2(NUM_REQ)-1:0]}, shifts every cycle. Stage 0 is loaded with {transfer, granted id}.
REQ-023 When the final tag stage is valid and dp_out_valid=1: rsp_valid[id]=1 and rsp_data=dp_out, combinationally. At all other times rsp_valid=0 and rsp_data=0.
REQ-024 The inflight counter (clog2(LATENCY+1) bits) increments on a transfer and decrements on a response. A simultaneous transfer and response leaves it unchanged. It never exceeds LATENCY.
REQ-025 err is set to 1 when the final tag valid differs from dp_out_valid. err stays set until reset.
REQ-026 The err comparison is suppressed for the first LATENCY cycles after reset deasserts; a post-reset counter tracks this.
REQ-027 Data passes through unmodified. Wrap-around, e.g. 0xFF->0x00, is the datapath's behaviour; the arbiter does not check it.
REQ-028 Dropping en during a grant cycle still completes that transfer; the FSM moves to DRAIN in the next cycle.

Reset
REQ-029 While reset=1 (sampled synchronously):
- FSM goes to IDLE.
- last_grant is set to NUM_REQ-1, so requester 0 has first priority.
- All tag stages are invalidated; inflight=0; err=0; the post-reset suppress counter is loaded.
REQ-030 Output values during and after reset: req_ready=0, dp_in_valid=0, dp_in=0, rsp_valid=0, rsp_data=0, idle=1, err=0.
REQ-031 Tags in flight when reset asserts are discarded. Results arriving after reset produce no rsp_valid and do not set err.

Verification (NUM_REQ=4, DATA_W=8, LATENCY=1)
REQ-032 Assert reset 2 cycles -> all outputs 0, idle=1, err=0.
REQ-033 en=1, only req_valid[2] with data 0x10 -> req_ready=4'b0100 and dp_in=0x10, dp_in_valid=1 in the same cycle; next cycle dp_out=0x11 with dp_out_valid=1 -> rsp_valid=4'b0100, rsp_data=0x11.
REQ-034 en=1, req_valid=4'b1111 held for 5 cycles -> req_ready sequence 0001, 0010, 0100, 1000, 0001; responses follow one cycle later in the same order.
REQ-035 Grant req 1 with data 0xFF, en dropped in the same cycle -> next cycle state is DRAIN, req_ready=0, rsp_valid=4'b0010 with rsp_data=0x00; the following cycle idle=1.
REQ-036 dp_out_valid=1 with no tag in flight, more than LATENCY cycles after reset -> err=1, and it stays 1 until reset.
REQ-037 Grant req 3, then reset asserted in the next cycle while dp_out_valid=1 -> rsp_valid=0 and err=0.
